// File: rtl/irq_ctrl.sv
// External interrupt controller: latched/masked sources, fixed priority, claim/complete register port.
// Define IRQ_SYNC_EN to insert a 2-flop synchroniser on every irq_src bit.

module irq_ctrl_lane (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic mode,
  input  logic clr,
  output logic pend
);
  logic src_s, src_prev;

`ifdef IRQ_SYNC_EN
  logic sync1, sync2;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end
  assign src_s = sync2;
`else
  assign src_s = src;
`endif

  // Edge mode: a new edge in the same cycle as a clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev <= 1'b0;
      pend     <= 1'b0;
    end else begin
      src_prev <= src_s;
      pend     <= mode ? ((pend & ~clr) | (src_s & ~src_prev)) : src_s;
    end
  end
endmodule

module irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic               cfg_re,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_out
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t              state, state_n;
  logic [NUM_SRC-1:0]  enable, mode, pending, req, clr, sel_oh;
  logic [ID_W-1:0]     sel, cur_id;
  logic                claim_rd, claim_wr, any_req;
  logic [31:0]         rdata_n;
  logic                unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:NUM_SRC];

  assign req      = pending & enable;
  assign any_req  = |req;
  assign claim_rd = cfg_re && (cfg_addr == 2'd3) && (state == S_ASSERT) && any_req;
  assign claim_wr = cfg_we && (cfg_addr == 2'd3);

  always_comb begin
    sel    = '0;
    sel_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel       = ID_W'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Lanes ignore clr in level mode, so W1C and claim clears can be applied blindly.
  assign clr = ((cfg_we && cfg_addr == 2'd2) ? cfg_wdata[NUM_SRC-1:0] : '0)
             | (claim_rd ? sel_oh : '0);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    irq_ctrl_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .src  (irq_src[i]),
      .mode (mode[i]),
      .clr  (clr[i]),
      .pend (pending[i])
    );
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (any_req) state_n = S_ASSERT;
      S_ASSERT:  if (claim_rd) state_n = S_SERVICE;
                 else if (!any_req) state_n = S_IDLE;
      S_SERVICE: if (claim_wr && cfg_wdata[ID_W-1:0] == cur_id) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_n = '0;
    case (cfg_addr)
      2'd0: rdata_n = 32'(enable);
      2'd1: rdata_n = 32'(mode);
      2'd2: rdata_n = 32'(pending);
      2'd3: if (claim_rd) rdata_n = {1'b1, {(31-ID_W){1'b0}}, sel};
      default: rdata_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_id    <= '0;
      enable    <= '0;
      mode      <= '0;
      cfg_rdata <= '0;
      irq_out   <= 1'b0;
    end else begin
      state   <= state_n;
      irq_out <= (state_n == S_ASSERT);
      if (claim_rd) cur_id <= sel;
      if (cfg_we && cfg_addr == 2'd0) enable <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_we && cfg_addr == 2'd1) mode   <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_re) cfg_rdata <= rdata_n;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: reset, edge, priority, level, masking, collision.
module tb_irq_ctrl;
  localparam int NUM_SRC = 4;
  localparam int ID_W    = 3;
`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] irq_src;
  logic               cfg_we, cfg_re;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;
  logic               irq_out;
  logic [31:0]        rv, hold;
  int                 n_tests = 0;
  int                 n_fail  = 0;

  irq_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_re    (cfg_re),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_out   (irq_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_re = 1'b1; cfg_addr = a;
    tick();
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] v);
    irq_src = v;
    tick();
    irq_src = '0;
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!irq_out && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(irq_out), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    // T1 reset
    repeat (2) tick();
    chk("rst_irq", 32'(irq_out), 32'd0);
    chk("rst_rdata", cfg_rdata, 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      chk($sformatf("rst_rd%0d", a), rv, 32'd0);
    end

    // T2 single edge source, exact latency
    wr(2'd0, 32'h1);
    wr(2'd1, 32'h1);
    pulse(4'b0001);
    repeat (SL) tick();
    chk("t2_irq_early", 32'(irq_out), 32'd0);
    tick();
    chk("t2_irq_on", 32'(irq_out), 32'd1);
    rd(2'd3, rv);
    chk("t2_claim", rv, 32'h8000_0000);
    chk("t2_irq_off", 32'(irq_out), 32'd0);
    hold = cfg_rdata;
    tick();
    chk("t2_rdata_hold", cfg_rdata, hold);
    rd(2'd2, rv);
    chk("t2_pend_clr", rv, 32'd0);
    rd(2'd3, rv);
    chk("t2_claim_service", rv, 32'd0);
    wr(2'd3, 32'd0);
    rd(2'd3, rv);
    chk("t2_claim_idle", rv, 32'd0);

    // T3 priority
    wr(2'd0, 32'hF);
    wr(2'd1, 32'hF);
    pulse(4'b1010);
    wait_irq("t3_irq");
    rd(2'd3, rv);
    chk("t3_claim1", rv, 32'h8000_0001);
    rd(2'd2, rv);
    chk("t3_pend", rv, 32'h8);
    wr(2'd3, 32'd1);
    chk("t3_irq_gap", 32'(irq_out), 32'd0);
    tick();
    chk("t3_irq_re", 32'(irq_out), 32'd1);
    rd(2'd3, rv);
    chk("t3_claim3", rv, 32'h8000_0003);
    wr(2'd3, 32'd3);
    rd(2'd2, rv);
    chk("t3_pend_empty", rv, 32'd0);

    // T4 level source
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h4);
    irq_src = 4'b0100;
    wait_irq("t4_irq");
    rd(2'd3, rv);
    chk("t4_claim", rv, 32'h8000_0002);
    rd(2'd2, rv);
    chk("t4_pend_level", rv, 32'h4);
    wr(2'd3, 32'd2);
    chk("t4_irq_gap", 32'(irq_out), 32'd0);
    tick();
    chk("t4_irq_re", 32'(irq_out), 32'd1);
    irq_src = '0;
    repeat (SL + 2) tick();
    chk("t4_irq_drop", 32'(irq_out), 32'd0);
    rd(2'd3, rv);
    chk("t4_claim_idle", rv, 32'd0);

    // T5 masking and mismatching complete
    wr(2'd1, 32'h2);
    wr(2'd0, 32'h2);
    pulse(4'b0010);
    wait_irq("t5_irq");
    wr(2'd0, 32'h0);
    tick();
    chk("t5_masked", 32'(irq_out), 32'd0);
    rd(2'd2, rv);
    chk("t5_pend_kept", rv, 32'h2);
    wr(2'd0, 32'h2);
    wait_irq("t5_irq_again");
    rd(2'd3, rv);
    chk("t5_claim", rv, 32'h8000_0001);
    wr(2'd3, 32'd3);
    chk("t5_mismatch_irq", 32'(irq_out), 32'd0);
    rd(2'd3, rv);
    chk("t5_claim_in_service", rv, 32'd0);
    pulse(4'b0010);
    repeat (SL + 2) tick();
    chk("t5_service_quiet", 32'(irq_out), 32'd0);
    rd(2'd2, rv);
    chk("t5_edge_in_service", rv, 32'h2);
    wr(2'd2, 32'h2);
    rd(2'd2, rv);
    chk("t5_w1c", rv, 32'd0);
    wr(2'd3, 32'd1);
    repeat (2) tick();
    chk("t5_idle", 32'(irq_out), 32'd0);
    // simultaneous write and read, upper bits masked
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h5;
    tick();
    cfg_we = 1'b0; cfg_re = 1'b0;
    chk("t5_rw_pre", cfg_rdata, 32'h2);
    wr(2'd0, 32'hFF);
    rd(2'd0, rv);
    chk("t5_en_mask", rv, 32'hF);
    wr(2'd0, 32'h0);

    // T6 edge set collides with claim clear
    wr(2'd1, 32'h1);
    wr(2'd0, 32'h1);
    pulse(4'b0001);
    wait_irq("t6_irq");
    irq_src = 4'b0001;
    rd(2'd3, rv);
    irq_src = '0;
    chk("t6_claim", rv, 32'h8000_0000);
    repeat (SL) tick();
    rd(2'd2, rv);
    chk("t6_pend_set", rv, 32'h1);
    wr(2'd3, 32'd0);
    wait_irq("t6_irq_re");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
